// File: rtl/logic_unit_pkg.sv
// Shared op-code definitions for the registered logic unit.
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NAND  = 3'd2,
    OP_NOR   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOT_A = 3'd6,
    OP_NOT_B = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise op select, optional OR-reduction to one bit, and result flags.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [OP_W-1:0]  op_in,
  input  logic             reduce_in,
  output logic [WIDTH-1:0] res_out,
  output logic             zero_out,
  output logic             parity_out
);

  logic [WIDTH-1:0] bitwise;

  always_comb begin
    bitwise = '0;
    case (op_e'(op_in))
      OP_AND:   bitwise = a_in & b_in;
      OP_OR:    bitwise = a_in | b_in;
      OP_NAND:  bitwise = ~(a_in & b_in);
      OP_NOR:   bitwise = ~(a_in | b_in);
      OP_XOR:   bitwise = a_in ^ b_in;
      OP_XNOR:  bitwise = ~(a_in ^ b_in);
      OP_NOT_A: bitwise = ~a_in;
      OP_NOT_B: bitwise = ~b_in;
      default:  bitwise = '0;
    endcase
  end

  // Reduction written as a bit-0 assignment so WIDTH=1 needs no zero-width fill.
  always_comb begin
    res_out = bitwise;
    if (reduce_in) begin
      res_out    = '0;
      res_out[0] = |bitwise;
    end
  end

  assign zero_out   = (res_out == '0);
  assign parity_out = ^res_out;

endmodule

// File: rtl/logic_unit_pipe.sv
// Single-register valid/ready logic unit with registered flags and saturating fire counter.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [OP_W-1:0]  op_in,
  input  logic             reduce_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] res_out,
  output logic             zero_out,
  output logic             parity_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count_out
);

  logic [WIDTH-1:0] core_res;
  logic             core_zero;
  logic             core_parity;
  logic             in_fire;
  logic             out_fire;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a_in       (a_in),
    .b_in       (b_in),
    .op_in      (op_in),
    .reduce_in  (reduce_in),
    .res_out    (core_res),
    .zero_out   (core_zero),
    .parity_out (core_parity)
  );

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      res_out    <= '0;
      zero_out   <= 1'b1;
      parity_out <= 1'b0;
      out_valid  <= 1'b0;
    end else if (in_fire) begin
      res_out    <= core_res;
      zero_out   <= core_zero;
      parity_out <= core_parity;
      out_valid  <= 1'b1;
    end else if (out_fire) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_out <= '0;
    end else if (out_fire && (count_out != '1)) begin
      count_out <= count_out + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (default widths plus a CNT_W=2 instance).
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       reduce;
  logic       in_valid, out_ready;
  logic       in_ready;
  logic [7:0] res;
  logic       zero, parity, out_valid;
  logic [15:0] count;

  logic       in_valid2, out_ready2, in_ready2;
  logic [7:0] res2;
  logic       zero2, parity2, out_valid2;
  logic [1:0] count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .a_in(a), .b_in(b), .op_in(op),
    .reduce_in(reduce), .in_valid(in_valid), .in_ready(in_ready),
    .res_out(res), .zero_out(zero), .parity_out(parity),
    .out_valid(out_valid), .out_ready(out_ready), .count_out(count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk_in(clk), .rst_n_in(rst_n), .a_in(a), .b_in(b), .op_in(op),
    .reduce_in(reduce), .in_valid(in_valid2), .in_ready(in_ready2),
    .res_out(res2), .zero_out(zero2), .parity_out(parity2),
    .out_valid(out_valid2), .out_ready(out_ready2), .count_out(count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set with in_valid high and advance one edge.
  task automatic send(input logic [7:0] av, input logic [7:0] bv,
                      input logic [2:0] opv, input logic rv);
    a = av; b = bv; op = opv; reduce = rv; in_valid = 1'b1;
    step();
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3A, 8'hC5};
    rst_n = 1'b0; a = '0; b = '0; op = '0; reduce = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; in_valid2 = 1'b0; out_ready2 = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(res), 32'h00);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_parity", 32'(parity), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_count_sat", 32'(count2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Op sweep, back to back with out_ready high
    for (int i = 0; i < 8; i++) begin
      send(8'hC5, 8'h3A, 3'(i), 1'b0);
      chk($sformatf("sweep_op%0d_res", i), 32'(res), 32'(sweep_exp[i]));
      chk($sformatf("sweep_op%0d_valid", i), 32'(out_valid), 32'd1);
    end
    chk("sweep_count", 32'(count), 32'd7);

    send(8'h5A, 8'h5A, OP_XOR, 1'b0);
    chk("xor_eq_res", 32'(res), 32'h00);
    chk("xor_eq_zero", 32'(zero), 32'd1);
    chk("xor_eq_parity", 32'(parity), 32'd0);
    send(8'h07, 8'h03, OP_AND, 1'b0);
    chk("and_res", 32'(res), 32'h03);
    chk("and_zero", 32'(zero), 32'd0);
    chk("and_parity", 32'(parity), 32'd0);

    send(8'h10, 8'h00, OP_OR, 1'b1);
    chk("red_or_res", 32'(res), 32'h01);
    chk("red_or_parity", 32'(parity), 32'd1);
    chk("red_or_zero", 32'(zero), 32'd0);
    send(8'hF0, 8'h0F, OP_AND, 1'b1);
    chk("red_and_res", 32'(res), 32'h00);
    chk("red_and_zero", 32'(zero), 32'd1);

    in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_res_hold", 32'(res), 32'h00);
    chk("drain_count", 32'(count), 32'd12);

    // Backpressure: three stalled cycles with changing A
    out_ready = 1'b0;
    send(8'h11, 8'h00, OP_OR, 1'b0);
    chk("bp_first_res", 32'(res), 32'h11);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      send(8'(i * 8'h11), 8'h00, OP_OR, 1'b0);
      chk($sformatf("bp_stall%0d_res", i), 32'(res), 32'h11);
      chk($sformatf("bp_stall%0d_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_stall%0d_valid", i), 32'(out_valid), 32'd1);
    end
    chk("bp_stall_count", 32'(count), 32'd12);
    a = 8'h55;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_next_res", 32'(res), 32'h55);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_count_1", 32'(count), 32'd13);
    in_valid = 1'b0;
    step();
    chk("bp_count_2", 32'(count), 32'd14);
    chk("bp_done_valid", 32'(out_valid), 32'd0);
    chk("bp_res_hold", 32'(res), 32'h55);

    // Saturation on the CNT_W=2 instance
    in_valid2 = 1'b1;
    step();
    chk("sat_count_0", 32'(count2), 32'd0);
    step(); chk("sat_count_1", 32'(count2), 32'd1);
    step(); chk("sat_count_2", 32'(count2), 32'd2);
    step(); chk("sat_count_3", 32'(count2), 32'd3);
    step(); chk("sat_count_4", 32'(count2), 32'd3);
    step(); chk("sat_count_5", 32'(count2), 32'd3);
    in_valid2 = 1'b0;
    step();

    // Async reset while stalled
    out_ready = 1'b0;
    send(8'hC5, 8'h3A, OP_OR, 1'b0);
    in_valid = 1'b0;
    chk("stall_res", 32'(res), 32'hFF);
    chk("stall_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_res", 32'(res), 32'h00);
    chk("arst_zero", 32'(zero), 32'd1);
    chk("arst_parity", 32'(parity), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_count_sat", 32'(count2), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
